// File: rtl/mips_multicycle_controller.sv
// ============================================================================
// Module   : mips_multicycle_controller
// Brief    : Multi-cycle MIPS control FSM with memory handshake and retire count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mips_multicycle_controller #(
  parameter int MEM_WAIT_EN = 1,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [5:0]       Func,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             RegWrite,
  output logic             AluSrcA,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       AluOperation,
  output logic             InstrDone,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetiredCount,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_LW_WB    = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13
  } state_t;

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_BNE  = 6'b000101;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
  localparam logic [5:0] c_OP_SLTI = 6'b001010;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_JAL  = 6'b000011;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;
  localparam logic [5:0] c_FN_JR  = 6'b001000;

  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_ready;
  logic       w_pcWrite, w_iorD, w_memRead, w_memWrite, w_irWrite;
  logic [1:0] w_regDst, w_memToReg, w_aluSrcB, w_pcSrc;
  logic       w_regWrite, w_aluSrcA, w_instrDone, w_illegal;
  logic [2:0] w_aluOp;
  logic [2:0] w_rAluOp;
  logic       w_rLegal;

  assign w_ready = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

  // R-type function decode; jr is legal but never reaches EXEC_R
  always_comb begin
    w_rLegal = 1'b1;
    w_rAluOp = c_ALU_ADD;
    case (Func)
      c_FN_ADD: w_rAluOp = c_ALU_ADD;
      c_FN_SUB: w_rAluOp = c_ALU_SUB;
      c_FN_AND: w_rAluOp = c_ALU_AND;
      c_FN_OR:  w_rAluOp = c_ALU_OR;
      c_FN_SLT: w_rAluOp = c_ALU_SLT;
      c_FN_JR:  w_rAluOp = c_ALU_ADD;
      default:  w_rLegal = 1'b0;
    endcase
  end

  always_comb begin
    w_pcWrite   = 1'b0;
    w_iorD      = 1'b0;
    w_memRead   = 1'b0;
    w_memWrite  = 1'b0;
    w_irWrite   = 1'b0;
    w_regDst    = 2'd0;
    w_memToReg  = 2'd0;
    w_regWrite  = 1'b0;
    w_aluSrcA   = 1'b0;
    w_aluSrcB   = 2'd0;
    w_pcSrc     = 2'd0;
    w_aluOp     = c_ALU_AND;
    w_instrDone = 1'b0;
    w_illegal   = 1'b0;
    w_next      = S_FETCH;
    case (r_state)
      S_FETCH: begin
        w_memRead = 1'b1;
        w_aluSrcB = 2'd1;
        w_aluOp   = c_ALU_ADD;
        if (w_ready) begin
          w_irWrite = 1'b1;
          w_pcWrite = 1'b1;
          w_next    = S_DECODE;
        end else begin
          w_next    = S_FETCH;
        end
      end
      S_DECODE: begin
        w_aluSrcB = 2'd3;
        w_aluOp   = c_ALU_ADD;
        case (OpCode)
          c_OP_LW, c_OP_SW:     w_next = S_MEM_ADDR;
          c_OP_BEQ, c_OP_BNE:   w_next = S_BRANCH;
          c_OP_ADDI, c_OP_SLTI: w_next = S_EXEC_I;
          c_OP_J:               w_next = S_JUMP;
          c_OP_JAL:             w_next = S_JAL;
          c_OP_R: begin
            if (!w_rLegal)          w_illegal = 1'b1;
            else if (Func == c_FN_JR) w_next  = S_JR;
            else                    w_next    = S_EXEC_R;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'd2;
        w_aluOp   = c_ALU_ADD;
        w_next    = (OpCode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        w_memRead = 1'b1;
        w_iorD    = 1'b1;
        w_next    = w_ready ? S_LW_WB : S_MEM_RD;
      end
      S_LW_WB: begin
        w_regWrite  = 1'b1;
        w_memToReg  = 2'd1;
        w_instrDone = 1'b1;
      end
      S_MEM_WR: begin
        w_memWrite  = 1'b1;
        w_iorD      = 1'b1;
        w_instrDone = w_ready;
        w_next      = w_ready ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        w_aluSrcA = 1'b1;
        w_aluOp   = w_rAluOp;
        w_next    = S_R_WB;
      end
      S_R_WB: begin
        w_regWrite  = 1'b1;
        w_regDst    = 2'd1;
        w_instrDone = 1'b1;
      end
      S_EXEC_I: begin
        w_aluSrcA = 1'b1;
        w_aluSrcB = 2'd2;
        w_aluOp   = (OpCode == c_OP_SLTI) ? c_ALU_SLT : c_ALU_ADD;
        w_next    = S_I_WB;
      end
      S_I_WB: begin
        w_regWrite  = 1'b1;
        w_instrDone = 1'b1;
      end
      S_BRANCH: begin
        w_aluSrcA   = 1'b1;
        w_aluOp     = c_ALU_SUB;
        w_pcSrc     = 2'd1;
        w_instrDone = 1'b1;
        w_pcWrite   = (OpCode == c_OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        w_pcSrc     = 2'd2;
        w_pcWrite   = 1'b1;
        w_instrDone = 1'b1;
      end
      // PC already holds PC+4 from FETCH, so it is the link value
      S_JAL: begin
        w_pcSrc     = 2'd2;
        w_pcWrite   = 1'b1;
        w_regWrite  = 1'b1;
        w_regDst    = 2'd2;
        w_memToReg  = 2'd2;
        w_instrDone = 1'b1;
      end
      S_JR: begin
        w_pcSrc     = 2'd3;
        w_pcWrite   = 1'b1;
        w_instrDone = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_instrDone) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Every output is forced low while reset is held
  assign PCWrite      = w_pcWrite & ~rst;
  assign IorD         = w_iorD & ~rst;
  assign MemRead      = w_memRead & ~rst;
  assign MemWrite     = w_memWrite & ~rst;
  assign IRWrite      = w_irWrite & ~rst;
  assign RegDst       = rst ? 2'd0 : w_regDst;
  assign MemToReg     = rst ? 2'd0 : w_memToReg;
  assign RegWrite     = w_regWrite & ~rst;
  assign AluSrcA      = w_aluSrcA & ~rst;
  assign AluSrcB      = rst ? 2'd0 : w_aluSrcB;
  assign PCSrc        = rst ? 2'd0 : w_pcSrc;
  assign AluOperation = rst ? 3'd0 : w_aluOp;
  assign InstrDone    = w_instrDone & ~rst;
  assign Illegal      = w_illegal & ~rst;
  assign RetiredCount = rst ? '0 : r_retired;
  assign State        = rst ? 4'd0 : r_state;

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_controller.sv
// ============================================================================
// Module   : tb_mips_multicycle_controller
// Brief    : Directed self-checking bench for the multi-cycle MIPS controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mips_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OpCode, Func;
  logic       Zero, MemReady;

  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, AluSrcA;
  logic [1:0]  RegDst, MemToReg, AluSrcB, PCSrc;
  logic [2:0]  AluOperation;
  logic        InstrDone, Illegal;
  logic [31:0] RetiredCount;
  logic [3:0]  State;

  logic        n_PCWrite, n_IorD, n_MemRead, n_MemWrite, n_IRWrite, n_RegWrite, n_AluSrcA;
  logic [1:0]  n_RegDst, n_MemToReg, n_AluSrcB, n_PCSrc;
  logic [2:0]  n_AluOperation;
  logic        n_InstrDone, n_Illegal;
  logic [1:0]  n_RetiredCount;
  logic [3:0]  n_State;

  int vectors = 0;
  int miscompares = 0;

  logic [19:0] allOut;
  assign allOut = {PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                   AluSrcA, AluSrcB, PCSrc, AluOperation, InstrDone, Illegal};

  mips_multicycle_controller #(.MEM_WAIT_EN(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PCSrc(PCSrc), .AluOperation(AluOperation),
    .InstrDone(InstrDone), .Illegal(Illegal), .RetiredCount(RetiredCount), .State(State)
  );

  // Narrow counter copy driven by the same instruction stream
  mips_multicycle_controller #(.MEM_WAIT_EN(1), .CNT_W(2)) dutNarrow (
    .clk(clk), .rst(rst), .OpCode(OpCode), .Func(Func), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(n_PCWrite), .IorD(n_IorD), .MemRead(n_MemRead), .MemWrite(n_MemWrite),
    .IRWrite(n_IRWrite), .RegDst(n_RegDst), .MemToReg(n_MemToReg), .RegWrite(n_RegWrite),
    .AluSrcA(n_AluSrcA), .AluSrcB(n_AluSrcB), .PCSrc(n_PCSrc), .AluOperation(n_AluOperation),
    .InstrDone(n_InstrDone), .Illegal(n_Illegal), .RetiredCount(n_RetiredCount), .State(n_State)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIn(input logic [5:0] op, input logic [5:0] fn);
    OpCode = op;
    Func   = fn;
    #1;
  endtask

  initial begin
    rst = 1'b1; OpCode = 6'b000000; Func = 6'b100000; Zero = 1'b0; MemReady = 1'b1;
    tick(); tick();
    chk("rst_allOut", 32'(allOut), 32'h0);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_count", RetiredCount, 32'd0);
    rst = 1'b0; #1;

    // add
    chk("fetch_state", 32'(State), 32'd0);
    chk("fetch_memread", 32'(MemRead), 32'd1);
    chk("fetch_irwrite", 32'(IRWrite), 32'd1);
    chk("fetch_pcwrite", 32'(PCWrite), 32'd1);
    chk("fetch_alusrcb", 32'(AluSrcB), 32'd1);
    chk("fetch_count0", RetiredCount, 32'd0);
    tick();
    chk("add_decode", 32'(State), 32'd1);
    chk("add_decode_srcb", 32'(AluSrcB), 32'd3);
    tick();
    chk("add_execr", 32'(State), 32'd6);
    chk("add_aluop", 32'(AluOperation), 32'b010);
    chk("add_execr_srca", 32'(AluSrcA), 32'd1);
    tick();
    chk("add_rwb", 32'(State), 32'd7);
    chk("add_regwrite", 32'(RegWrite), 32'd1);
    chk("add_regdst", 32'(RegDst), 32'd1);
    chk("add_done", 32'(InstrDone), 32'd1);
    tick();
    chk("add_count", RetiredCount, 32'd1);

    // lw with 3 wait cycles in MEM_RD: 8 cycles total
    setIn(6'b100011, 6'b000000);
    chk("lw_fetch", 32'(State), 32'd0);
    tick();
    chk("lw_decode", 32'(State), 32'd1);
    tick();
    chk("lw_memaddr", 32'(State), 32'd2);
    chk("lw_memaddr_srcb", 32'(AluSrcB), 32'd2);
    MemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lw_wait_state", 32'(State), 32'd3);
      chk("lw_wait_memread", 32'(MemRead), 32'd1);
      chk("lw_wait_iord", 32'(IorD), 32'd1);
    end
    tick();
    MemReady = 1'b1; #1;
    chk("lw_rd_ready", 32'(State), 32'd3);
    tick();
    chk("lw_wb", 32'(State), 32'd4);
    chk("lw_memtoreg", 32'(MemToReg), 32'd1);
    chk("lw_regwrite", 32'(RegWrite), 32'd1);
    chk("lw_done", 32'(InstrDone), 32'd1);
    tick();
    chk("lw_count", RetiredCount, 32'd2);

    // beq, Zero=1
    setIn(6'b000100, 6'b000000);
    Zero = 1'b1;
    tick(); tick();
    chk("beq_state", 32'(State), 32'd10);
    chk("beq_pcwrite", 32'(PCWrite), 32'd1);
    chk("beq_pcsrc", 32'(PCSrc), 32'd1);
    chk("beq_aluop", 32'(AluOperation), 32'b110);
    chk("beq_done", 32'(InstrDone), 32'd1);
    tick();
    chk("beq_count", RetiredCount, 32'd3);

    // bne, Zero=1 then Zero=0 within the same BRANCH cycle
    setIn(6'b000101, 6'b000000);
    tick(); tick();
    chk("bne_z1_pcwrite", 32'(PCWrite), 32'd0);
    chk("bne_done", 32'(InstrDone), 32'd1);
    Zero = 1'b0; #1;
    chk("bne_z0_pcwrite", 32'(PCWrite), 32'd1);
    tick();
    chk("bne_count", RetiredCount, 32'd4);
    chk("narrow_wrap", 32'(n_RetiredCount), 32'd0);

    // jal
    setIn(6'b000011, 6'b000000);
    tick(); tick();
    chk("jal_state", 32'(State), 32'd12);
    chk("jal_pcwrite", 32'(PCWrite), 32'd1);
    chk("jal_regdst", 32'(RegDst), 32'd2);
    chk("jal_memtoreg", 32'(MemToReg), 32'd2);
    chk("jal_regwrite", 32'(RegWrite), 32'd1);
    chk("jal_pcsrc", 32'(PCSrc), 32'd2);
    tick();
    chk("jal_count", RetiredCount, 32'd5);

    // jr
    setIn(6'b000000, 6'b001000);
    tick();
    chk("jr_decode_legal", 32'(Illegal), 32'd0);
    tick();
    chk("jr_state", 32'(State), 32'd13);
    chk("jr_pcsrc", 32'(PCSrc), 32'd3);
    chk("jr_regwrite", 32'(RegWrite), 32'd0);
    chk("jr_pcwrite", 32'(PCWrite), 32'd1);
    tick();
    chk("jr_count", RetiredCount, 32'd6);

    // illegal opcode
    setIn(6'b111111, 6'b000000);
    tick();
    chk("ill_flag", 32'(Illegal), 32'd1);
    chk("ill_done", 32'(InstrDone), 32'd0);
    tick();
    chk("ill_back_fetch", 32'(State), 32'd0);
    chk("ill_count", RetiredCount, 32'd6);

    // illegal R function
    setIn(6'b000000, 6'b111111);
    tick();
    chk("illfn_flag", 32'(Illegal), 32'd1);
    tick();
    chk("illfn_back_fetch", 32'(State), 32'd0);

    // sw with one wait cycle; MemWrite held across the wait
    setIn(6'b101011, 6'b000000);
    tick(); tick();
    MemReady = 1'b0;
    tick();
    chk("sw_state", 32'(State), 32'd5);
    chk("sw_memwrite", 32'(MemWrite), 32'd1);
    chk("sw_wait_nodone", 32'(InstrDone), 32'd0);
    tick();
    chk("sw_wait_memwrite", 32'(MemWrite), 32'd1);
    MemReady = 1'b1; #1;
    chk("sw_done", 32'(InstrDone), 32'd1);
    tick();
    chk("sw_count", RetiredCount, 32'd7);

    // slti with a stalled fetch
    setIn(6'b001010, 6'b000000);
    MemReady = 1'b0; #1;
    chk("fetchwait_irwrite", 32'(IRWrite), 32'd0);
    chk("fetchwait_pcwrite", 32'(PCWrite), 32'd0);
    tick();
    chk("fetchwait_state", 32'(State), 32'd0);
    MemReady = 1'b1;
    tick(); tick();
    chk("slti_state", 32'(State), 32'd8);
    chk("slti_aluop", 32'(AluOperation), 32'b111);
    tick();
    chk("slti_iwb", 32'(State), 32'd9);
    chk("slti_regdst", 32'(RegDst), 32'd0);
    tick();
    chk("slti_count", RetiredCount, 32'd8);

    // reset raised while lw waits in MEM_RD
    setIn(6'b100011, 6'b000000);
    tick(); tick();
    MemReady = 1'b0;
    tick();
    chk("rstmid_memrd", 32'(State), 32'd3);
    rst = 1'b1; #1;
    chk("rstmid_allOut", 32'(allOut), 32'h0);
    tick();
    rst = 1'b0; MemReady = 1'b1; #1;
    chk("rstmid_state", 32'(State), 32'd0);
    chk("rstmid_count", RetiredCount, 32'd0);
    chk("rstmid_nodone", 32'(InstrDone), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
